player_bullet: RTL
==================

# player_bullet

Player projectile controller: consumes the player block's `shoot_bullet` request and `player_X` position, launches a single bullet from the cannon, advances it up the screen once per frame, and retires it on an alien/shield hit or on reaching the top of the playfield. It sits between the player stage and the collision/draw logic, which read its position and active flag. Only one player bullet exists at a time, with a refire cooldown.

## Interface
Parameters:
- `BULLET_Y_START`, 440: launch Y, the top of the player cannon.
- `BULLET_Y_MIN`, 0: topmost legal Y.
- `BULLET_STEP`, 4: pixels moved upward per frame.
- `COOLDOWN`, 8: frames spent in COOLDOWN after a bullet retires. Must be ≥1.

Ports:
- `frame_clk`  in  1  frame-rate clock (one edge per video frame).
- `Reset`  in  1  asynchronous, active-high reset.
- `shoot_bullet`  in  1  fire request from the player block; level, held while the key is held.
- `player_X`  in  10  current player centre X, unsigned.
- `hit`  in  1  from collision logic; the bullet overlapped a target this frame.
- `bullet_X`  out  10  bullet centre X.
- `bullet_Y`  out  10  bullet top Y.
- `bullet_active`  out  1  bullet exists and must be drawn and collided.
- `fire_event`  out  1  one-frame pulse on launch, for sound and shot counter.

## Operation
- Three-state FSM:
  - IDLE: no bullet; can fire.
  - FLYING: bullet in motion.
  - COOLDOWN: bullet retired; refire is blocked.
- `shoot_prev` register holds the `shoot_bullet` value from the previous edge. A fire trigger is `shoot_bullet & ~shoot_prev` (rising edge). `shoot_prev` updates every edge in every state.
- IDLE, on fire trigger:
  - `bullet_X <= player_X` and `bullet_Y <= BULLET_Y_START`.
  - `bullet_active <= 1` and `fire_event <= 1`.
  - Next state is FLYING.
- IDLE, otherwise: all outputs hold; `fire_event <= 0`.
- FLYING, in priority order:
  1. `hit=1`: `bullet_active <= 0`, load cooldown counter with `COOLDOWN-1`, go to COOLDOWN.
  2. `bullet_Y < BULLET_Y_MIN + BULLET_STEP`: same retire action as a hit. This compare prevents unsigned underflow and wrap-around to the bottom of the screen.
  3. Otherwise `bullet_Y <= bullet_Y - BULLET_STEP`.
- FLYING, other rules:
  - `fire_event <= 0`.
  - `bullet_X` is constant for the flight; player movement does not affect it.
  - Fire requests are ignored.
- COOLDOWN:
  - Counter decrements each edge.
  - When the counter is 0, go to IDLE.
  - Fire triggers are dropped, not queued.
  - `bullet_X` and `bullet_Y` hold their last values; `bullet_active=0`.
- `hit` is ignored outside FLYING.
- Arithmetic is 10-bit unsigned. Counter width is sufficient for `COOLDOWN-1`.

## Timing
- All state and outputs are registered on posedge `frame_clk`. Inputs are sampled at that edge.
- Reset values: state=IDLE, `bullet_X=0`, `bullet_Y=0`, `bullet_active=0`, `fire_event=0`, `shoot_prev=0`, counter=0.
- Reset mid-flight or mid-cooldown clears outputs immediately, without waiting for a clock edge.
- Launch latency: a trigger sampled at edge N gives `bullet_active=1` and `fire_event=1` after edge N. The first upward move happens at edge N+1.
- `fire_event` is high for exactly one frame per launch.
- Retire latency: `hit` sampled at edge M gives `bullet_active=0` after edge M. The earliest next launch happens at edge M+COOLDOWN+1.

## Configuration
- `PLAYER_BULLET_AUTOFIRE_EN` defined: the fire trigger in IDLE is the `shoot_bullet` level. Holding fire relaunches on the first edge spent in IDLE.
- Undefined (default): the trigger is the rising edge only. A held key fires exactly once, and a new press is required for the next shot.

## Test plan
- Fire and fly: reset, `player_X=320`, raise `shoot_bullet` for 1 frame.
  - After edge 1: `bullet_active=1`, `bullet_X=320`, `bullet_Y=440`, `fire_event=1`.
  - After edge 2: `bullet_Y=436`, `fire_event=0`.
- Top-of-screen expiry, no hit:
  - `bullet_Y` reaches 0 at the 110th move.
  - At the next edge `bullet_active=0` and `bullet_Y` does not wrap.
  - A new press is accepted only after 8 cooldown frames.
- Hit: assert `hit` while `bullet_Y=300`.
  - `bullet_active=0` at the next edge.
  - A press during cooldown produces no launch and no `fire_event`.
- Held key: hold `shoot_bullet` for 300 frames.
  - Macro undefined: exactly 1 `fire_event`.
  - Macro defined: relaunch on the first IDLE frame after each cooldown.
- Player moves during flight: sweep `player_X` from 320 to 100 while FLYING; `bullet_X` stays 320.
- Asynchronous reset mid-flight: pulse `Reset` between clock edges; outputs clear immediately and a subsequent press launches normally.

Source files
------------

// File: rtl/player_bullet.sv
// Player projectile: launch, per-frame climb, retire on hit/top, refire cooldown.
// Define PLAYER_BULLET_AUTOFIRE_EN to fire on the shoot level instead of its rising edge.
module player_bullet #(
    parameter int BULLET_Y_START = 440,
    parameter int BULLET_Y_MIN   = 0,
    parameter int BULLET_STEP    = 4,
    parameter int COOLDOWN       = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       shoot_bullet,
    input  logic [9:0] player_X,
    input  logic       hit,
    output logic [9:0] bullet_X,
    output logic [9:0] bullet_Y,
    output logic       bullet_active,
    output logic       fire_event
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [9:0]    Y_START = 10'(BULLET_Y_START);
    localparam logic [9:0]    Y_STEP  = 10'(BULLET_STEP);
    localparam logic [9:0]    Y_LIMIT = 10'(BULLET_Y_MIN + BULLET_STEP);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLYING,
        S_COOLDOWN
    } state_t;

    state_t        state;
    logic          shoot_prev;
    logic [CW-1:0] cd_cnt;
    logic          fire_trig;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
    assign fire_trig = shoot_bullet;
`else
    assign fire_trig = shoot_bullet & ~shoot_prev;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            shoot_prev    <= 1'b0;
            cd_cnt        <= '0;
            bullet_X      <= '0;
            bullet_Y      <= '0;
            bullet_active <= 1'b0;
            fire_event    <= 1'b0;
        end else begin
            shoot_prev <= shoot_bullet;
            fire_event <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (fire_trig) begin
                        bullet_X      <= player_X;
                        bullet_Y      <= Y_START;
                        bullet_active <= 1'b1;
                        fire_event    <= 1'b1;
                        state         <= S_FLYING;
                    end
                end
                S_FLYING: begin
                    // Retire before subtracting so Y never wraps to the bottom.
                    if (hit || (bullet_Y < Y_LIMIT)) begin
                        bullet_active <= 1'b0;
                        cd_cnt        <= CD_LOAD;
                        state         <= S_COOLDOWN;
                    end else begin
                        bullet_Y <= bullet_Y - Y_STEP;
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
